// File: rtl/rv32_hart_pc_sched_pkg.sv
// Shared types and defaults for the pito barrel scheduler: hart count, hart id and PC types.
package rv32_hart_pc_sched_pkg;

    localparam int unsigned PITO_NUM_HARTS = 8;
    localparam int unsigned PITO_HART_ID_W = $clog2(PITO_NUM_HARTS);
    localparam int unsigned RV32_PC_W      = 32;

    typedef logic [PITO_HART_ID_W-1:0] hart_id_t;
    typedef logic [RV32_PC_W-1:0]      rv32_pc_cnt_t;

    localparam rv32_pc_cnt_t PITO_RESET_PC = '0;

endpackage

// File: rtl/rv32_hart_pc_sched_arb.sv
// Rotating-priority arbiter: grants the first requester strictly after ptr_i, wrapping.
module rv32_rr_arbiter #(
    parameter  int unsigned N     = 8,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // N is a power of two, so index arithmetic wraps for free; k == N revisits ptr_i last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 1; k <= int'(N); k++) begin
            cand = ptr_i + IDX_W'(k);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32_hart_pc_sched.sv
// Per-hart PC owner and barrel issue scheduler: one fetch grant per cycle, one
// instruction in flight per hart, PC retired from the next-PC stage resolve.
module rv32_hart_pc_sched
    import rv32_hart_pc_sched_pkg::*;
#(
    parameter  int unsigned     NUM_HARTS = PITO_NUM_HARTS,
    parameter  int unsigned     PC_W      = RV32_PC_W,
    parameter  logic [PC_W-1:0] RESET_PC  = PC_W'(PITO_RESET_PC),
    localparam int unsigned     HID_W     = $clog2(NUM_HARTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_i,
    input  logic                 stall_i,
    input  logic [NUM_HARTS-1:0] hart_en_i,
    input  logic                 res_valid_i,
    input  logic [HID_W-1:0]     res_hart_id_i,
    input  logic                 res_new_pc_i,
    input  logic [PC_W-1:0]      res_pc_i,
    output logic                 fetch_valid_o,
    output logic [HID_W-1:0]     fetch_hart_id_o,
    output logic [PC_W-1:0]      fetch_pc_o,
    output logic [NUM_HARTS-1:0] hart_busy_o,
    output logic                 err_spur_o,
    output logic                 err_misalign_o
);

    logic [PC_W-1:0]      pc_q [NUM_HARTS];
    logic [PC_W-1:0]      pc_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] in_flight_q, in_flight_d;
    logic [HID_W-1:0]     ptr_q, ptr_d;
    logic                 fetch_valid_q, fetch_valid_d;
    logic [HID_W-1:0]     fetch_id_q, fetch_id_d;
    logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;
    logic                 err_spur_q, err_spur_d;
    logic                 err_mis_q, err_mis_d;

    logic [NUM_HARTS-1:0] eligible;
    logic [NUM_HARTS-1:0] arb_gnt;
    logic [HID_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 grant;
    logic                 res_hit;
    logic [PC_W-1:0]      res_target;

    // Eligibility uses only registered flags, so a hart resolved this cycle waits one more.
    assign eligible   = hart_en_i & ~in_flight_q;
    assign grant      = run_i & ~stall_i & arb_any;
    assign res_hit    = res_valid_i & in_flight_q[res_hart_id_i];
    assign res_target = {res_pc_i[PC_W-1:2], 2'b00};

    rv32_rr_arbiter #(
        .N (NUM_HARTS)
    ) u_arb (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        pc_d          = pc_q;
        in_flight_d   = in_flight_q;
        ptr_d         = ptr_q;
        fetch_valid_d = 1'b0;
        fetch_id_d    = fetch_id_q;
        fetch_pc_d    = fetch_pc_q;
        err_spur_d    = err_spur_q;
        err_mis_d     = err_mis_q;

        if (res_valid_i) begin
            if (res_hit) begin
                pc_d[res_hart_id_i]        = res_new_pc_i ? res_target
                                                          : pc_q[res_hart_id_i] + PC_W'(4);
                in_flight_d[res_hart_id_i] = 1'b0;
                if (res_new_pc_i && (res_pc_i[1:0] != 2'b00)) begin
                    err_mis_d = 1'b1;
                end
            end else begin
                err_spur_d = 1'b1;
            end
        end

        // The granted hart was idle, so it can never be the one being resolved.
        if (grant) begin
            fetch_valid_d = 1'b1;
            fetch_id_d    = arb_idx;
            fetch_pc_d    = pc_q[arb_idx];
            in_flight_d   = in_flight_d | arb_gnt;
            ptr_d         = arb_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_HARTS); i++) begin
                pc_q[i] <= RESET_PC;
            end
            in_flight_q   <= '0;
            ptr_q         <= HID_W'(NUM_HARTS - 1);
            fetch_valid_q <= 1'b0;
            fetch_id_q    <= '0;
            fetch_pc_q    <= '0;
            err_spur_q    <= 1'b0;
            err_mis_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            in_flight_q   <= in_flight_d;
            ptr_q         <= ptr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_id_q    <= fetch_id_d;
            fetch_pc_q    <= fetch_pc_d;
            err_spur_q    <= err_spur_d;
            err_mis_q     <= err_mis_d;
        end
    end

    assign fetch_valid_o   = fetch_valid_q;
    assign fetch_hart_id_o = fetch_id_q;
    assign fetch_pc_o      = fetch_pc_q;
    assign hart_busy_o     = in_flight_q;
    assign err_spur_o      = err_spur_q;
    assign err_misalign_o  = err_mis_q;

endmodule

// File: tb/tb_rv32_hart_pc_sched.sv
// Bench for rv32_hart_pc_sched: directed scenarios plus a random run, all cycles
// compared against a per-hart behavioural model.
module tb_rv32_hart_pc_sched;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  hart_en = '0;
    logic        res_valid = 1'b0;
    logic [2:0]  res_hart_id = '0;
    logic        res_new_pc = 1'b0;
    logic [31:0] res_pc = '0;

    logic        fetch_valid;
    logic [2:0]  fetch_hart_id;
    logic [31:0] fetch_pc;
    logic [7:0]  hart_busy;
    logic        err_spur;
    logic        err_misalign;

    rv32_hart_pc_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run_i           (run),
        .stall_i         (stall),
        .hart_en_i       (hart_en),
        .res_valid_i     (res_valid),
        .res_hart_id_i   (res_hart_id),
        .res_new_pc_i    (res_new_pc),
        .res_pc_i        (res_pc),
        .fetch_valid_o   (fetch_valid),
        .fetch_hart_id_o (fetch_hart_id),
        .fetch_pc_o      (fetch_pc),
        .hart_busy_o     (hart_busy),
        .err_spur_o      (err_spur),
        .err_misalign_o  (err_misalign)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_pc [N];
    logic [7:0]  m_busy;
    int          m_ptr;
    logic        m_fv;
    int          m_fid;
    logic [31:0] m_fpc;
    logic        m_spur;
    logic        m_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pc[i] = 32'h0;
        m_busy = '0;
        m_ptr  = N - 1;
        m_fv   = 1'b0;
        m_fid  = 0;
        m_fpc  = 32'h0;
        m_spur = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("fetch_valid", 64'(fetch_valid), 64'(m_fv));
        chk("fetch_hart_id", 64'(fetch_hart_id), 64'(m_fid));
        chk("fetch_pc", 64'(fetch_pc), 64'(m_fpc));
        chk("hart_busy", 64'(hart_busy), 64'(m_busy));
        chk("err_spur", 64'(err_spur), 64'(m_spur));
        chk("err_misalign", 64'(err_misalign), 64'(m_mis));
    endtask

    // One clock: predict from the spec rules, clock the DUT, compare, drop the resolve.
    task automatic step();
        int          g;
        int          c;
        int          h;
        logic [7:0]  elig;
        logic [7:0]  prev_busy;
        elig = hart_en & ~m_busy;
        g = -1;
        if (run && !stall) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && elig[c]) g = c;
            end
        end
        if (res_valid) begin
            h = int'(res_hart_id);
            if (m_busy[h]) begin
                m_pc[h]   = res_new_pc ? (res_pc & 32'hFFFF_FFFC) : m_pc[h] + 32'd4;
                m_busy[h] = 1'b0;
                if (res_new_pc && res_pc[1:0] != 2'b00) m_mis = 1'b1;
            end else begin
                m_spur = 1'b1;
            end
        end
        if (g >= 0) begin
            m_fv      = 1'b1;
            m_fid     = g;
            m_fpc     = m_pc[g];
            m_busy[g] = 1'b1;
            m_ptr     = g;
        end else begin
            m_fv = 1'b0;
        end
        prev_busy = hart_busy;
        @(posedge clk);
        #1;
        if (fetch_valid === 1'b1)
            chk("no_double_issue", 64'(prev_busy[fetch_hart_id]), 64'd0);
        check_outputs();
        res_valid = 1'b0;
    endtask

    task automatic resolve(input int h, input logic np, input logic [31:0] pc);
        res_valid   = 1'b1;
        res_hart_id = 3'(h);
        res_new_pc  = np;
        res_pc      = pc;
    endtask

    // Asynchronous reset asserted between edges; ends at a negedge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        res_valid = 1'b0;
        #2;
        model_reset();
        check_outputs();
        chk("reset_busy_zero", 64'(hart_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_cycle();
        int h;
        int s;
        int c;
        run   = ($urandom % 8) != 0;
        stall = ($urandom % 4) == 0;
        if ($urandom % 16 == 0) hart_en = 8'($urandom);
        h = -1;
        if (m_busy != 0 && ($urandom % 3) != 0) begin
            s = int'($urandom % N);
            for (int k = 0; k < N; k++) begin
                c = (s + k) % N;
                if (h < 0 && m_busy[c]) h = c;
            end
            if ($urandom % 4 == 0) resolve(h, 1'b1, $urandom);
            else if ($urandom % 2 == 0) resolve(h, 1'b1, $urandom & 32'hFFFF_FFFC);
            else resolve(h, 1'b0, 32'h0);
        end else if (m_busy != 8'hFF && ($urandom % 20) == 0) begin
            s = int'($urandom % N);
            for (int k = 0; k < N; k++) begin
                c = (s + k) % N;
                if (h < 0 && !m_busy[c]) h = c;
            end
            resolve(h, 1'b0, 32'h0);
        end
        step();
    endtask

    initial begin
        #1;
        do_reset();

        // Scenario 1: all harts granted in order from reset
        run = 1'b1;
        hart_en = 8'hFF;
        for (int i = 0; i < N; i++) begin
            step();
            chk("t1_order", 64'(fetch_hart_id), 64'(i));
            chk("t1_pc", 64'(fetch_pc), 64'd0);
        end
        step();
        chk("t1_idle", 64'(fetch_valid), 64'd0);
        chk("t1_all_busy", 64'(hart_busy), 64'hFF);

        // Scenario 2: pc+4 and redirect on hart 3
        resolve(3, 1'b1, 32'h100);
        step();
        step();
        chk("t2_pc_100", 64'(fetch_pc), 64'h100);
        resolve(3, 1'b0, 32'h0);
        step();
        chk("t2_no_same_cycle", 64'(fetch_valid), 64'd0);
        step();
        chk("t2_pc_104", 64'(fetch_pc), 64'h104);
        resolve(3, 1'b1, 32'h2000);
        step();
        step();
        chk("t2_pc_2000", 64'(fetch_pc), 64'h2000);

        // Scenario 3: two enabled harts, stall window
        do_reset();
        hart_en = 8'b0010_0100;
        run = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            stall = (cyc >= 4 && cyc < 7);
            if (m_busy[2]) resolve(2, 1'b0, 32'h0);
            else if (m_busy[5]) resolve(5, 1'b0, 32'h0);
            step();
            if (stall) chk("t3_stall_nogrant", 64'(fetch_valid), 64'd0);
            if (fetch_valid)
                chk("t3_id_ok", 64'(fetch_hart_id == 3'd2 || fetch_hart_id == 3'd5), 64'd1);
        end
        stall = 1'b0;

        // Scenario 4: spurious and misaligned resolves
        do_reset();
        hart_en = 8'h00;
        run = 1'b0;
        resolve(6, 1'b0, 32'h0);
        step();
        chk("t4_spur", 64'(err_spur), 64'd1);
        hart_en = 8'b0100_0000;
        run = 1'b1;
        step();
        chk("t4_pc6_kept", 64'(fetch_pc), 64'd0);
        resolve(6, 1'b1, 32'h1003);
        step();
        chk("t4_misalign", 64'(err_misalign), 64'd1);
        step();
        chk("t4_aligned_pc", 64'(fetch_pc), 64'h1000);

        // Scenario 5: PC wrap and same-cycle resolve/grant of different harts
        do_reset();
        hart_en = 8'b0000_0010;
        run = 1'b1;
        step();
        resolve(1, 1'b1, 32'hFFFF_FFFC);
        step();
        step();
        chk("t5_pc_top", 64'(fetch_pc), 64'hFFFF_FFFC);
        resolve(1, 1'b0, 32'h0);
        step();
        step();
        chk("t5_pc_wrap", 64'(fetch_pc), 64'h0);
        hart_en = 8'b0000_0110;
        resolve(1, 1'b0, 32'h0);
        step();
        chk("t5_grant2", 64'(fetch_hart_id), 64'd2);
        chk("t5_busy", 64'(hart_busy), 64'h04);
        step();
        chk("t5_regrant1", 64'(fetch_hart_id), 64'd1);
        chk("t5_pc4", 64'(fetch_pc), 64'h4);

        // Scenario 6: random traffic with a mid-stream reset
        hart_en = 8'hFF;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 250) begin
                do_reset();
                for (int i = 0; i < N; i++) chk("t6_reset_pc", 64'(m_pc[i]), 64'd0);
            end else begin
                random_cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
